// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit seven-segment display path.
//
// Contents:
//   NUM_DIGITS    - number of multiplexed digits
//   SEG_BLANK     - active-low segment pattern with every segment off
//   AN_OFF        - active-low anode pattern with every digit off
//   HEX_SEG_TABLE - 16-entry hex-to-segment table, {g,f,e,d,c,b,a}, active-low
//   hex_to_seg()  - table lookup helper
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'hF;

    // Entry [n] is the pattern for hex digit n; the literal lists F down to 0.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_digit_mux_if.sv
// Bus between the display controller and the seven-segment digit multiplexer.
//
// Signals:
//   dig_sel [1:0]  - current digit index from the digit-select counter
//   value   [15:0] - hex value to display, nibble 3 is the leftmost digit
//   load           - one-cycle strobe capturing value/dp_in into pending
//   dp_in   [3:0]  - per-digit decimal-point enables, active-high
//   lz_en          - leading-zero suppression enable
//   busy           - pending value not yet shown
//   an      [3:0]  - anode enables, active-low
//   seg     [6:0]  - segments {g,f,e,d,c,b,a}, active-low
//   dp             - decimal point, active-low
//
// Modports: master drives the controls and observes the display lines,
// slave is the multiplexer itself.
interface seg7_digit_mux_if;
    import seg7_pkg::*;

    logic [1:0]            dig_sel;
    logic [15:0]           value;
    logic                  load;
    logic [NUM_DIGITS-1:0] dp_in;
    logic                  lz_en;
    logic                  busy;
    logic [NUM_DIGITS-1:0] an;
    logic [6:0]            seg;
    logic                  dp;

    modport master (
        output dig_sel, value, load, dp_in, lz_en,
        input  busy, an, seg, dp
    );

    modport slave (
        input  dig_sel, value, load, dp_in, lz_en,
        output busy, an, seg, dp
    );

endinterface

// File: rtl/hex7seg.sv
// Combinational hex-to-seven-segment decoder.
//
// Ports:
//   nibble [3:0] - hex digit in
//   seg    [6:0] - segments {g,f,e,d,c,b,a}, active-low
module hex7seg
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_digit_mux.sv
// Seven-segment digit multiplexer for a 4-digit display.
//
// Latches a 16-bit hex value into a pending register on load, transfers it
// into the display register at the start of a frame (dig_sel wrapping to 0),
// and drives the digit chosen by dig_sel onto registered active-low anode,
// segment and decimal-point lines. Every digit change is followed by an
// anode dead time to stop ghosting; leading zeros may be blanked.
//
// Parameters:
//   BLANK_CYCLES - dead-time count after each dig_sel change (0..4094)
//   CNT_W        - width of the dead-time counter, must hold BLANK_CYCLES
//
// Ports:
//   clock - system clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - slave side of seg7_digit_mux_if (controls in, display lines out)
module seg7_digit_mux
    import seg7_pkg::*;
#(
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned CNT_W        = 12
) (
    input  logic             clock,
    input  logic             reset,
    seg7_digit_mux_if.slave  bus
);

    // Digit-change tracking.
    logic [1:0] sel_q;
    logic       chg;
    logic       frame_start;

    // Pending / display registers.
    logic [15:0]           pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic [15:0]           disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic                  busy_q, busy_d;

    // Dead-time counter and registered outputs.
    logic [CNT_W-1:0]      blank_cnt_q, blank_cnt_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    // Decode path for the currently selected digit.
    logic [3:0] cur_nib;
    logic [6:0] cur_seg;
    logic       lz_blank;

    assign chg         = (bus.dig_sel != sel_q);
    assign frame_start = chg && (bus.dig_sel == 2'd0);

    // Pending capture and frame transfer. A load coinciding with a frame
    // start moves the old pending value to the display and keeps busy set
    // for the newly captured one.
    always_comb begin
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        busy_d     = busy_q;

        if (frame_start && busy_q) begin
            disp_val_d = pend_val_q;
            disp_dp_d  = pend_dp_q;
            busy_d     = 1'b0;
        end

        if (bus.load) begin
            pend_val_d = bus.value;
            pend_dp_d  = bus.dp_in;
            busy_d     = 1'b1;
        end
    end

    // Selected nibble and leading-zero decision, both from the display
    // register so they only change at frame boundaries.
    always_comb begin
        cur_nib  = 4'h0;
        lz_blank = 1'b0;
        unique case (sel_q)
            2'd0: begin
                cur_nib  = disp_val_q[3:0];
                lz_blank = 1'b0;
            end
            2'd1: begin
                cur_nib  = disp_val_q[7:4];
                lz_blank = (disp_val_q[15:4] == 12'h000);
            end
            2'd2: begin
                cur_nib  = disp_val_q[11:8];
                lz_blank = (disp_val_q[15:8] == 8'h00);
            end
            2'd3: begin
                cur_nib  = disp_val_q[15:12];
                lz_blank = (disp_val_q[15:12] == 4'h0);
            end
            default: begin
                cur_nib  = 4'h0;
                lz_blank = 1'b0;
            end
        endcase
    end

    hex7seg u_hex7seg (
        .nibble (cur_nib),
        .seg    (cur_seg)
    );

    // Dead time: a digit change reloads the counter and blanks the outputs;
    // they stay blank until the counter has drained to zero.
    always_comb begin
        blank_cnt_d = blank_cnt_q;
        an_d        = AN_OFF;
        seg_d       = SEG_BLANK;
        dp_d        = 1'b1;

        if (chg) begin
            blank_cnt_d = CNT_W'(BLANK_CYCLES);
        end else if (blank_cnt_q != '0) begin
            blank_cnt_d = blank_cnt_q - CNT_W'(1);
        end else begin
            an_d  = ~(NUM_DIGITS'(1) << sel_q);
            // A suppressed digit keeps its anode and decimal point.
            seg_d = (bus.lz_en && lz_blank) ? SEG_BLANK : cur_seg;
            dp_d  = ~disp_dp_q[sel_q];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sel_q       <= 2'd0;
            pend_val_q  <= '0;
            pend_dp_q   <= '0;
            disp_val_q  <= '0;
            disp_dp_q   <= '0;
            busy_q      <= 1'b0;
            blank_cnt_q <= CNT_W'(BLANK_CYCLES);
            an_q        <= AN_OFF;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
        end else begin
            sel_q       <= bus.dig_sel;
            pend_val_q  <= pend_val_d;
            pend_dp_q   <= pend_dp_d;
            disp_val_q  <= disp_val_d;
            disp_dp_q   <= disp_dp_d;
            busy_q      <= busy_d;
            blank_cnt_q <= blank_cnt_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.an   = an_q;
    assign bus.seg  = seg_q;
    assign bus.dp   = dp_q;

endmodule

// File: tb/tb_seg7_digit_mux.sv
// Directed, self-checking bench for seg7_digit_mux with BLANK_CYCLES=3.
module tb_seg7_digit_mux;
    import seg7_pkg::*;

    localparam int unsigned BLANK = 3;

    logic clock;
    logic reset;

    seg7_digit_mux_if bus ();

    seg7_digit_mux #(
        .BLANK_CYCLES (BLANK),
        .CNT_W        (12)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Watches for the stale value in the last-write-wins sequence.
    logic watch_one = 1'b0;
    logic saw_one   = 1'b0;
    always @(negedge clock) begin
        if (watch_one && bus.seg === 7'h79) saw_one <= 1'b1;
    end

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp_in;
        logic        lz_en;
        logic [1:0]  digit;
        logic [6:0]  seg;
        logic        dp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Change the digit and wait until the dead time has fully elapsed.
    task automatic set_sel(input logic [1:0] d);
        bus.dig_sel = d;
        repeat (BLANK + 2) tick();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dpi);
        bus.value = v;
        bus.dp_in = dpi;
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
    endtask

    task automatic check_digit(input string name, input logic [1:0] d,
                               input logic [6:0] s, input logic p);
        logic [3:0] an_exp;
        an_exp    = 4'hF;
        an_exp[d] = 1'b0;
        check({name, ".an"}, 32'(bus.an), 32'(an_exp));
        check({name, ".seg"}, 32'(bus.seg), 32'(s));
        check({name, ".dp"}, 32'(bus.dp), 32'(p));
    endtask

    initial begin
        // value, dp_in, lz_en, digit, seg, dp
        vecs.push_back('{16'h12AF, 4'b0000, 1'b0, 2'd0, 7'h0E, 1'b1});
        vecs.push_back('{16'h12AF, 4'b0000, 1'b0, 2'd1, 7'h08, 1'b1});
        vecs.push_back('{16'h12AF, 4'b0000, 1'b0, 2'd2, 7'h24, 1'b1});
        vecs.push_back('{16'h12AF, 4'b0000, 1'b0, 2'd3, 7'h79, 1'b1});
        vecs.push_back('{16'h0042, 4'b0000, 1'b1, 2'd3, 7'h7F, 1'b1});
        vecs.push_back('{16'h0042, 4'b0000, 1'b1, 2'd2, 7'h7F, 1'b1});
        vecs.push_back('{16'h0042, 4'b0000, 1'b1, 2'd1, 7'h19, 1'b1});
        vecs.push_back('{16'h0042, 4'b0000, 1'b1, 2'd0, 7'h24, 1'b1});
        vecs.push_back('{16'h0000, 4'b0000, 1'b1, 2'd3, 7'h7F, 1'b1});
        vecs.push_back('{16'h0000, 4'b0000, 1'b1, 2'd1, 7'h7F, 1'b1});
        vecs.push_back('{16'h0000, 4'b0000, 1'b1, 2'd0, 7'h40, 1'b1});
        vecs.push_back('{16'h0000, 4'b0000, 1'b0, 2'd2, 7'h40, 1'b1});
        vecs.push_back('{16'h3456, 4'b0101, 1'b0, 2'd0, 7'h02, 1'b0});
        vecs.push_back('{16'h3456, 4'b0101, 1'b0, 2'd1, 7'h12, 1'b1});
        vecs.push_back('{16'h3456, 4'b0101, 1'b0, 2'd2, 7'h19, 1'b0});
        vecs.push_back('{16'h3456, 4'b0101, 1'b0, 2'd3, 7'h30, 1'b1});
        vecs.push_back('{16'h789B, 4'b0000, 1'b0, 2'd0, 7'h03, 1'b1});
        vecs.push_back('{16'h789B, 4'b0000, 1'b0, 2'd1, 7'h10, 1'b1});
        vecs.push_back('{16'h789B, 4'b0000, 1'b0, 2'd2, 7'h00, 1'b1});
        vecs.push_back('{16'h789B, 4'b0000, 1'b0, 2'd3, 7'h78, 1'b1});
        vecs.push_back('{16'hCDE0, 4'b0000, 1'b1, 2'd0, 7'h40, 1'b1});
        vecs.push_back('{16'hCDE0, 4'b0000, 1'b1, 2'd1, 7'h06, 1'b1});
        vecs.push_back('{16'hCDE0, 4'b0000, 1'b1, 2'd2, 7'h21, 1'b1});
        vecs.push_back('{16'hCDE0, 4'b0000, 1'b1, 2'd3, 7'h46, 1'b1});
        vecs.push_back('{16'h0100, 4'b1000, 1'b1, 2'd3, 7'h7F, 1'b0});
        vecs.push_back('{16'h0100, 4'b1000, 1'b1, 2'd2, 7'h79, 1'b1});
        vecs.push_back('{16'h0100, 4'b1000, 1'b1, 2'd1, 7'h40, 1'b1});
        vecs.push_back('{16'h0100, 4'b1000, 1'b1, 2'd0, 7'h40, 1'b1});

        bus.dig_sel = 2'd0;
        bus.value   = 16'h0000;
        bus.load    = 1'b0;
        bus.dp_in   = 4'h0;
        bus.lz_en   = 1'b0;
        reset       = 1'b0;

        // Reset state and the blank window that follows release.
        #12;
        check("rst.an", 32'(bus.an), 32'hF);
        check("rst.seg", 32'(bus.seg), 32'h7F);
        check("rst.dp", 32'(bus.dp), 32'h1);
        check("rst.busy", 32'(bus.busy), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("blank0.an", 32'(bus.an), 32'hF);
        for (int i = 1; i < 4; i++) begin
            tick();
            check($sformatf("blank%0d.an", i), 32'(bus.an), 32'hF);
        end
        tick();
        check("post_blank.an", 32'(bus.an), 32'hE);
        check("post_blank.seg", 32'(bus.seg), 32'h40);

        // Load then frame transfer across 0,1,2,3,0.
        do_load(16'h12AF, 4'h0);
        check("xfer.busy_load", 32'(bus.busy), 32'h1);
        set_sel(2'd1);
        check("xfer.busy_1", 32'(bus.busy), 32'h1);
        set_sel(2'd2);
        check("xfer.busy_2", 32'(bus.busy), 32'h1);
        set_sel(2'd3);
        check("xfer.busy_3", 32'(bus.busy), 32'h1);
        check_digit("xfer.old_d3", 2'd3, 7'h40, 1'b1);
        bus.dig_sel = 2'd0;
        tick();
        check("xfer.busy_clr", 32'(bus.busy), 32'h0);
        check("xfer.blank_an", 32'(bus.an), 32'hF);
        repeat (BLANK + 1) tick();
        check_digit("xfer.d0", 2'd0, 7'h0E, 1'b1);
        set_sel(2'd3);
        check_digit("xfer.d3", 2'd3, 7'h79, 1'b1);

        // Table of decode / suppression / decimal-point cases.
        foreach (vecs[i]) begin
            bus.lz_en = vecs[i].lz_en;
            do_load(vecs[i].value, vecs[i].dp_in);
            check($sformatf("vec%0d.busy_set", i), 32'(bus.busy), 32'h1);
            set_sel(2'd3);
            set_sel(2'd0);
            check($sformatf("vec%0d.busy_clr", i), 32'(bus.busy), 32'h0);
            set_sel(vecs[i].digit);
            check_digit($sformatf("vec%0d", i), vecs[i].digit, vecs[i].seg, vecs[i].dp);
        end
        bus.lz_en = 1'b0;

        // Last write wins.
        set_sel(2'd1);
        do_load(16'h1111, 4'h0);
        do_load(16'h2222, 4'h0);
        check("lww.busy", 32'(bus.busy), 32'h1);
        bus.dig_sel = 2'd0;
        watch_one   = 1'b1;
        repeat (BLANK + 2) tick();
        check_digit("lww.d0", 2'd0, 7'h24, 1'b1);
        for (int d = 1; d < 4; d++) begin
            set_sel(2'(d));
            check_digit($sformatf("lww.d%0d", d), 2'(d), 7'h24, 1'b1);
        end
        watch_one = 1'b0;
        check("lww.no_stale", 32'(saw_one), 32'h0);

        // Load coinciding with frame_start.
        set_sel(2'd1);
        do_load(16'h0042, 4'h0);
        bus.dig_sel = 2'd0;
        bus.value   = 16'hBEEF;
        bus.load    = 1'b1;
        tick();
        bus.load    = 1'b0;
        check("coll.busy", 32'(bus.busy), 32'h1);
        repeat (BLANK + 1) tick();
        check_digit("coll.d0", 2'd0, 7'h24, 1'b1);
        set_sel(2'd1);
        check_digit("coll.d1", 2'd1, 7'h19, 1'b1);
        check("coll.busy_hold", 32'(bus.busy), 32'h1);
        set_sel(2'd0);
        check("coll.busy_clr", 32'(bus.busy), 32'h0);
        check_digit("coll.next_d0", 2'd0, 7'h0E, 1'b1);
        set_sel(2'd3);
        check_digit("coll.next_d3", 2'd3, 7'h03, 1'b1);

        // Asynchronous reset mid-frame with a pending value.
        set_sel(2'd2);
        check("rst_mid.an_before", 32'(bus.an), 32'hB);
        do_load(16'h5555, 4'h0);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid.an", 32'(bus.an), 32'hF);
        check("rst_mid.seg", 32'(bus.seg), 32'h7F);
        check("rst_mid.dp", 32'(bus.dp), 32'h1);
        check("rst_mid.busy", 32'(bus.busy), 32'h0);
        repeat (2) tick();
        reset = 1'b1;
        bus.dig_sel = 2'd0;
        repeat (BLANK + 3) tick();
        check("rst_mid.busy_after", 32'(bus.busy), 32'h0);
        check_digit("rst_mid.cleared", 2'd0, 7'h40, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_digit_mux.md
Name: seg7_digit_mux

Overview:
- Downstream consumer of the 2-bit digit-select counter in the 4-digit 7-segment display path.
- Takes a 16-bit hex value, latches it on a frame boundary and decodes the nibble chosen by dig_sel.
- Drives registered, active-low anode and segment lines.
- Inserts anti-ghosting blanking on every digit change and optionally suppresses leading zeros.

Parameters:
- BLANK_CYCLES, 16: anode dead-time count after each dig_sel change (0..4094).
- CNT_W, 12: width of the blanking counter. Must hold BLANK_CYCLES.

Ports:
- clock, input, 1: system clock. All state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- dig_sel, input, 2: current digit index from the digit-select counter. It changes at most once per 4096 clocks.
- value, input, 16: hex value to display. Nibble 3 is the leftmost digit.
- load, input, 1: one-cycle strobe that captures value and dp_in into the pending registers.
- dp_in, input, 4: decimal-point enables per digit, active-high.
- lz_en, input, 1: leading-zero suppression enable.
- busy, output, 1: high while the pending value is not yet shown.
- an, output, 4: anode enables, active-low, one-hot-low when driving.
- seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
- dp, output, 1: decimal point, active-low.

Behaviour:
- Reset (reset=0, asynchronous):
  - an=4'b1111, seg=7'h7F, dp=1, busy=0.
  - pending and display value registers = 0, dp registers = 0.
  - sel_q=0, blank_cnt=BLANK_CYCLES, so outputs are blanked after reset release.
- Change detect:
  - sel_q registers dig_sel every cycle.
  - chg = (dig_sel != sel_q).
  - frame_start = chg && dig_sel==2'd0.
- Load handshake:
  - load=1 writes value/dp_in into pending and sets busy=1 on the next edge.
  - A load while busy=1 overwrites pending (last write wins). There is no back-pressure.
- Frame transfer:
  - On frame_start with busy=1, the display registers take pending and busy clears.
  - Simultaneous load and frame_start: the old pending transfers, the new value is captured into pending, and busy stays 1.
  - Display registers never change mid-frame.
- Blanking timing:
  - On chg: blank_cnt<=BLANK_CYCLES and an<=4'hF, seg<=7'h7F, dp<=1.
  - Else if blank_cnt!=0: decrement, outputs stay blank.
  - Else: drive the outputs.
  - Outputs are blank for exactly BLANK_CYCLES+1 cycles after the edge on which chg is sampled.
- Drive (registered, 1-cycle latency from sel_q/display regs):
  - an = ~(1<<sel_q).
  - seg = hex7seg(display nibble sel_q).
  - dp = ~display_dp[sel_q].
- Leading-zero suppression (lz_en=1), applied to the display register:
  - digit 3 blanks when nib3==0.
  - digit 2 blanks when nib3==nib2==0.
  - digit 1 blanks when nib3..1 are all 0.
  - digit 0 never blanks.
  - A suppressed digit drives seg=7'h7F but still asserts its anode, and dp follows display_dp.
- Hex decode (active-low): 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
- dig_sel changing during an active blank window restarts blank_cnt.
- Reset asserted mid-frame returns all outputs to the blank state immediately and discards pending.

Decomposition:
- Shared package seg7_pkg holds:
  - NUM_DIGITS=4.
  - SEG_BLANK=7'h7F and AN_OFF=4'hF.
  - The 16-entry hex-to-segment constant table.
- One combinational sub-module, hex7seg (4-bit nibble in, 7-bit active-low segments out), instantiated once on the selected nibble.

Test Plan:
- Reset and blank window, BLANK_CYCLES=3:
  - Stimulus: release reset with dig_sel=0.
  - Required: an=4'hF for 4 cycles, then an=4'hE and seg=7'h40.
- Load then frame transfer:
  - Stimulus: load value=16'h12AF, step dig_sel 0,1,2,3,0.
  - Required: busy=1 until the 3->0 change, then digit0 shows F (7'h0E) and digit3 shows 1 (7'h79), and busy=0.
- Last write wins:
  - Stimulus: load 16'h1111, then load 16'h2222 before frame_start.
  - Required: 16'h2222 is displayed. 16'h1111 never appears on seg.
- Load collides with frame_start:
  - Stimulus: load 16'hBEEF on the same cycle as frame_start, with pending=16'h0042.
  - Required: 16'h0042 is displayed and busy stays 1. 16'hBEEF is displayed after the next frame_start.
- Leading-zero suppression:
  - Stimulus: value=16'h0042, lz_en=1.
  - Required: digits 3 and 2 show seg=7'h7F, digit1 shows 7'h19, digit0 shows 7'h24.
  - Stimulus: value=16'h0000.
  - Required: only digit0 shows 7'h40.
- Reset mid-frame:
  - Stimulus: assert reset while an=4'hB.
  - Required: an=4'hF, seg=7'h7F, dp=1, busy=0, with no clock edge needed.
